// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default datapath widths, opcode classes and fetch FSM states.
package cpu_pkg;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned INSTR_W = 32;

    // Opcode class carried in IR[31:29]
    localparam logic [2:0] OPC_ARITH  = 3'd0;
    localparam logic [2:0] OPC_DATA   = 3'd1;
    localparam logic [2:0] OPC_BRANCH = 3'd2;
    localparam logic [2:0] OPC_JUMP   = 3'd3;
    localparam logic [2:0] OPC_CMP    = 3'd4;
    localparam logic [2:0] OPC_FLOP   = 3'd5;
    localparam logic [2:0] OPC_LOGIC  = 3'd6;
    localparam logic [2:0] OPC_SHIFT  = 3'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } fetch_state_t;

    function automatic logic [2:0] opcode_class(input logic [31:0] instr);
        return instr[31:29];
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: single-outstanding imem handshake, IR register toward decode,
// and PC redirect with squash of any in-flight fetch.
module fetch_unit #(
    parameter int unsigned       ADDR_W   = cpu_pkg::ADDR_W,
    parameter int unsigned       INSTR_W  = cpu_pkg::INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       PC_STEP  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] ir,
    output logic [ADDR_W-1:0]  ir_pc,
    output logic               ir_valid,
    input  logic               ir_ready,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc
);
    import cpu_pkg::*;

    fetch_state_t        state, state_d;
    logic [ADDR_W-1:0]   pc, pc_d;
    logic [INSTR_W-1:0]  ir_d;
    logic [ADDR_W-1:0]   ir_pc_d;
    logic                ir_valid_d;
    logic                drop, drop_d;
    logic                imem_req_d;

    // pc is a register, so the address output is registered as well
    assign imem_addr = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            ir       <= '0;
            ir_pc    <= '0;
            ir_valid <= 1'b0;
            drop     <= 1'b0;
            imem_req <= 1'b0;
        end else begin
            state    <= state_d;
            pc       <= pc_d;
            ir       <= ir_d;
            ir_pc    <= ir_pc_d;
            ir_valid <= ir_valid_d;
            drop     <= drop_d;
            imem_req <= imem_req_d;
        end
    end

    always_comb begin
        state_d    = state;
        pc_d       = pc;
        ir_d       = ir;
        ir_pc_d    = ir_pc;
        ir_valid_d = ir_valid;
        drop_d     = drop;

        unique case (state)
            IDLE: state_d = FETCH;
            FETCH: begin
                if (imem_gnt) state_d = WAIT;
            end
            WAIT: begin
                if (imem_rvalid) begin
                    if (drop) begin
                        drop_d  = 1'b0;
                        state_d = FETCH;
                    end else begin
                        ir_d       = imem_rdata;
                        ir_pc_d    = pc;
                        pc_d       = pc + ADDR_W'(PC_STEP);
                        ir_valid_d = 1'b1;
                        state_d    = HOLD;
                    end
                end
            end
            HOLD: begin
                if (ir_valid && ir_ready) begin
                    ir_valid_d = 1'b0;
                    state_d    = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase

        // Redirect overrides everything decided above for this cycle
        if (redirect) begin
            pc_d       = redirect_pc;
            ir_valid_d = 1'b0;
            ir_d       = ir;
            ir_pc_d    = ir_pc;
            unique case (state)
                FETCH: begin
                    if (imem_gnt) begin
                        drop_d  = 1'b1;
                        state_d = WAIT;
                    end else begin
                        state_d = FETCH;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        drop_d  = 1'b0;
                        state_d = FETCH;
                    end else begin
                        drop_d  = 1'b1;
                        state_d = WAIT;
                    end
                end
                default: state_d = FETCH;
            endcase
        end

        imem_req_d = (state_d == FETCH);
    end

    // A response is only legal while a granted request is outstanding
    a_rvalid_in_wait: assert property (@(posedge clk) disable iff (!rst_n)
        imem_rvalid |-> (state == WAIT));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomized checks of fetch_unit against a transaction-level model of the
// delivered instruction stream.
module tb_fetch_unit;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] ir;
    logic [31:0] ir_pc;
    logic        ir_valid;
    logic        ir_ready;
    logic        redirect;
    logic [31:0] redirect_pc;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;
    int unsigned n_fail = 0;

    fetch_unit #(
        .ADDR_W   (32),
        .INSTR_W  (32),
        .RESET_PC (32'h0000_0000),
        .PC_STEP  (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .ir          (ir),
        .ir_pc       (ir_pc),
        .ir_valid    (ir_valid),
        .ir_ready    (ir_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Instruction memory contents as a pure function of address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    logic [31:0] exp_pc, paddr, prev_addr, prev_ir, rpc;
    logic        pend, hold_prev, ir_hold_prev, g, rv, rdy, rdr;
    int unsigned dly, n_cons;

    initial begin
        rst_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        ir_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_valid", 32'(ir_valid), 32'd0);
        check("rst_ir", ir, 32'd0);
        check("rst_ir_pc", ir_pc, 32'd0);
        check("rst_addr", imem_addr, 32'd0);

        // First fetch: request in the 2nd cycle after release, grant, data next cycle
        rst_n = 1'b1;
        check("idle_no_req", 32'(imem_req), 32'd0);
        step();
        check("first_req", 32'(imem_req), 32'd1);
        check("first_addr", imem_addr, 32'd0);
        imem_gnt = 1'b1; step(); imem_gnt = 1'b0;
        check("wait_no_req", 32'(imem_req), 32'd0);
        imem_rvalid = 1'b1; imem_rdata = 32'hC000_0000; step();
        imem_rvalid = 1'b0; imem_rdata = 32'h1234_5678;
        check("t1_ir", ir, 32'hC000_0000);
        check("t1_ir_pc", ir_pc, 32'd0);
        check("t1_valid", 32'(ir_valid), 32'd1);
        check("t1_opclass", 32'(opcode_class(ir)), 32'(OPC_LOGIC));

        // Decode stalls: IR held, no new request
        for (int i = 0; i < 5; i++) begin
            check("stall_ir", ir, 32'hC000_0000);
            check("stall_valid", 32'(ir_valid), 32'd1);
            check("stall_req", 32'(imem_req), 32'd0);
            step();
        end
        ir_ready = 1'b1; step(); ir_ready = 1'b0;
        check("consume_valid", 32'(ir_valid), 32'd0);
        check("next_req", 32'(imem_req), 32'd1);
        check("next_addr", imem_addr, 32'd4);

        // Grant withheld: request and address stable
        for (int i = 0; i < 3; i++) begin
            check("nognt_req", 32'(imem_req), 32'd1);
            check("nognt_addr", imem_addr, 32'd4);
            step();
        end
        check("gnt4_addr", imem_addr, 32'd4);
        imem_gnt = 1'b1; step(); imem_gnt = 1'b0;
        check("gnt4_wait", 32'(imem_req), 32'd0);

        // Redirect in WAIT: stale response dropped
        redirect = 1'b1; redirect_pc = 32'h100; step(); redirect = 1'b0;
        check("rdw_req", 32'(imem_req), 32'd0);
        check("rdw_valid", 32'(ir_valid), 32'd0);
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; step(); imem_rvalid = 1'b0;
        check("drop_valid", 32'(ir_valid), 32'd0);
        check("drop_ir", ir, 32'hC000_0000);
        check("drop_req", 32'(imem_req), 32'd1);
        check("drop_addr", imem_addr, 32'h100);

        // Redirect in HOLD with ir_ready: squash, no consume
        imem_gnt = 1'b1; step(); imem_gnt = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'h4000_0000; step(); imem_rvalid = 1'b0;
        check("t5_ir", ir, 32'h4000_0000);
        check("t5_ir_pc", ir_pc, 32'h100);
        check("t5_valid", 32'(ir_valid), 32'd1);
        redirect = 1'b1; redirect_pc = 32'h40; ir_ready = 1'b1; step();
        redirect = 1'b0; ir_ready = 1'b0;
        check("rdh_valid", 32'(ir_valid), 32'd0);
        check("rdh_req", 32'(imem_req), 32'd1);
        check("rdh_addr", imem_addr, 32'h40);
        imem_gnt = 1'b1; step(); imem_gnt = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'h2000_0000; step(); imem_rvalid = 1'b0;
        check("rdh_ir_pc", ir_pc, 32'h40);
        check("rdh_ir", ir, 32'h2000_0000);

        // PC wrap from the top of the address space
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; step(); redirect = 1'b0;
        check("top_addr", imem_addr, 32'hFFFF_FFFC);
        imem_gnt = 1'b1; step(); imem_gnt = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'h6000_0000; step(); imem_rvalid = 1'b0;
        check("top_ir_pc", ir_pc, 32'hFFFF_FFFC);
        ir_ready = 1'b1; step(); ir_ready = 1'b0;
        check("wrap_req", 32'(imem_req), 32'd1);
        check("wrap_addr", imem_addr, 32'd0);

        // Asynchronous reset while in WAIT
        imem_gnt = 1'b1; step(); imem_gnt = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_req", 32'(imem_req), 32'd0);
        check("arst_valid", 32'(ir_valid), 32'd0);
        check("arst_ir", ir, 32'd0);
        check("arst_ir_pc", ir_pc, 32'd0);
        check("arst_addr", imem_addr, 32'd0);
        step(); step();
        rst_n = 1'b1;

        // Randomized traffic against the expected instruction stream
        exp_pc = 32'd0; pend = 1'b0; dly = 0; paddr = '0; n_cons = 0;
        hold_prev = 1'b0; ir_hold_prev = 1'b0; prev_addr = '0; prev_ir = '0;
        for (int c = 0; c < 3000; c++) begin
            step();
            g   = imem_req && ($urandom_range(0, 2) != 0);
            rv  = pend && (dly == 0);
            rdy = ($urandom_range(0, 3) != 0);
            rdr = ($urandom_range(0, 11) == 0);
            rpc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF4 : ($urandom & 32'hFFFF_FFFC);
            imem_gnt    = g;
            imem_rvalid = rv;
            imem_rdata  = rv ? mem_word(paddr) : $urandom;
            ir_ready    = rdy;
            redirect    = rdr;
            redirect_pc = rpc;

            if (hold_prev) begin
                check("rnd_req_hold", 32'(imem_req), 32'd1);
                check("rnd_addr_hold", imem_addr, prev_addr);
            end
            if (ir_hold_prev) check("rnd_ir_hold", ir, prev_ir);
            if (g && !rdr) check("rnd_fetch_addr", imem_addr, exp_pc);
            if (ir_valid && rdy && !rdr) begin
                check("rnd_ir_pc", ir_pc, exp_pc);
                check("rnd_ir", ir, mem_word(exp_pc));
                exp_pc = exp_pc + 32'd4;
                n_cons++;
            end
            if (rdr) exp_pc = rpc;

            hold_prev    = imem_req && !g && !rdr;
            prev_addr    = imem_addr;
            ir_hold_prev = ir_valid && !rdy && !rdr;
            prev_ir      = ir;

            if (rv) pend = 1'b0;
            else if (pend && dly > 0) dly--;
            if (g) begin
                pend  = 1'b1;
                paddr = imem_addr;
                dly   = $urandom_range(0, 2);
            end
        end
        check("rnd_progress", 32'(n_cons >= 100), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
